// File: rtl/lu_arb_pkg.sv
// Shared constants for the logic-unit arbiter: opcodes, stats counter width, tag sizing.
// Latency: n/a (package only).
// Backpressure: n/a.
package lu_arb_pkg;

    // Logic unit opcodes
    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_XOR = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Per-requester grant counter width
    localparam int STATS_W = 16;

    // Bits needed to encode a requester index; never less than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr.sv
// Round-robin pick among N requesters with a rotating priority pointer.
// Latency: grant is combinational from req; the pointer updates on the advance edge.
// Backpressure: a request is simply held until granted; the pointer moves only on advance.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] ptr;

    // Search from the pointer upward with wrap; first set request wins
    always_comb begin
        int               j;
        logic [IDX_W-1:0] j_idx;
        logic             found;
        gnt   = '0;
        idx   = '0;
        j     = 0;
        j_idx = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            j_idx = IDX_W'(j);
            if (!found && req[j_idx] && !rst) begin
                found      = 1'b1;
                gnt[j_idx] = 1'b1;
                idx        = j_idx;
            end
        end
    end

    // Winner drops to lowest priority: pointer moves just past it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            if (int'(idx) == N - 1) ptr <= '0;
            else                    ptr <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one external registered logic unit among NUM_REQ requesters; tags issues and routes results back.
// Latency: operands registered at the grant edge; response strobe LU_LATENCY+1 edges after it.
// Backpressure: requests held until granted; no response backpressure. Option macro LU_ARB_STATS_EN adds grant counters.
module logic_unit_arbiter
    import lu_arb_pkg::*;
#(
    parameter int data_size    = 8,
    parameter int op_code_size = 2,
    parameter int NUM_REQ      = 4,
    parameter int LU_LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            reset_ah_in,
    input  logic [NUM_REQ-1:0]              req_in,
    input  logic [NUM_REQ*data_size-1:0]    a_in,
    input  logic [NUM_REQ*data_size-1:0]    b_in,
    input  logic [NUM_REQ*op_code_size-1:0] op_code_in,
    output logic [NUM_REQ-1:0]              gnt_out,
    output logic [data_size-1:0]            lu_a_out,
    output logic [data_size-1:0]            lu_b_out,
    output logic [op_code_size-1:0]         lu_op_out,
    input  logic [data_size-1:0]            lu_result_in,
    output logic [NUM_REQ-1:0]              resp_valid_out,
    output logic [data_size-1:0]            resp_data_out,
    output logic                            busy_out
`ifdef LU_ARB_STATS_EN
    ,
    input  logic                            stats_clr_in,
    output logic [NUM_REQ*STATS_W-1:0]      grant_count_out
`endif
);

    localparam int TAG_W = clog2(NUM_REQ);
    localparam int NSTG  = LU_LATENCY + 1;

    logic [TAG_W-1:0] win_idx;
    logic             transfer;
    logic [NSTG-1:0]  stg_vld;
    logic [TAG_W-1:0] stg_tag [NSTG];

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (TAG_W)
    ) u_rr (
        .clk     (clk),
        .rst     (reset_ah_in),
        .req     (req_in),
        .advance (transfer),
        .gnt     (gnt_out),
        .idx     (win_idx)
    );

    assign transfer = |(req_in & gnt_out);

    // Capture the winner's operands into the unit-facing registers; hold otherwise
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            lu_a_out  <= '0;
            lu_b_out  <= '0;
            lu_op_out <= '0;
        end else if (transfer) begin
            lu_a_out  <= a_in[int'(win_idx)*data_size +: data_size];
            lu_b_out  <= b_in[int'(win_idx)*data_size +: data_size];
            lu_op_out <= op_code_in[int'(win_idx)*op_code_size +: op_code_size];
        end
    end

    // Tag pipeline tracks each issue through the unit's fixed latency
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            stg_vld <= '0;
            for (int i = 0; i < NSTG; i++) stg_tag[i] <= '0;
        end else begin
            stg_vld    <= {stg_vld[NSTG-2:0], transfer};
            stg_tag[0] <= win_idx;
            for (int i = 1; i < NSTG; i++) stg_tag[i] <= stg_tag[i-1];
        end
    end

    // Final stage pairs the unit's output with its originating requester
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            resp_valid_out <= '0;
            resp_data_out  <= '0;
        end else if (stg_vld[NSTG-1]) begin
            resp_valid_out <= NUM_REQ'(1) << stg_tag[NSTG-1];
            resp_data_out  <= lu_result_in;
        end else begin
            resp_valid_out <= '0;
        end
    end

    assign busy_out = |stg_vld;

`ifdef LU_ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt [NUM_REQ];

    // Saturating per-requester grant counters; clear wins over increment
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (stats_clr_in)
                    grant_cnt[i] <= '0;
                else if (req_in[i] && gnt_out[i] && (grant_cnt[i] != {STATS_W{1'b1}}))
                    grant_cnt[i] <= grant_cnt[i] + STATS_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count_out[g*STATS_W +: STATS_W] = grant_cnt[g];
    end
`endif

endmodule
